param_proc: RTL
===============

# param_proc

Parametrised multicycle processor: the next generation of the team's 16-bit bus-based CPU, generalised to `DATA_W`-bit data. It adds three instructions to the existing set: bitwise AND, conditional move on a zero flag, and load/store through a registered memory port. It also adds a `Run`-qualified fetch. It sits between the instruction/data source that drives `DIN` and an external synchronous RAM.

## Interface
- `DATA_W`, default 16: datapath width for R0-R7, A, G, bus and memory data; legal range ≥ 12.
- `ADDR_W`, default `DATA_W`: memory address width; the address is the low `ADDR_W` bits of Ry.
- `Clock`  in  1: single clock; all state updates on the rising edge.
- `Reset`  in  1: synchronous, active-high. It clears every register at the next rising edge.
- `Run`  in  1: instruction fetch qualifier, sampled in step T0 only.
- `DIN`  in  `DATA_W`: instruction word, mvi immediate, and load return data.
- `Done`  out  1: combinational; high in the final step of each instruction.
- `BusWires`  out  `DATA_W`: internal bus, observable.
- `ADDR`  out  `ADDR_W`: registered memory address.
- `DOUT`  out  `DATA_W`: registered memory write data.
- `W`  out  1: registered write strobe.

## Operation
- **Instruction format:** IR = `DIN[DATA_W-1 -: 9]` = III XXX YYY. The low `DATA_W-9` bits of an instruction word are ignored.
- **Opcodes:**
  - 000 mv: Rx←Ry
  - 001 mvi: Rx←next DIN word
  - 010 add: Rx←Rx+Ry
  - 011 sub: Rx←Rx−Ry
  - 100 and: Rx←Rx&Ry
  - 101 mvnz: Rx←Ry if Z=0
  - 110 ld: Rx←mem[Ry]
  - 111 st: mem[Ry]←Rx
- **Step counter:** 2-bit Tstep, states T0-T3. It clears to T0 on Reset, and after any step in which Done=1.
- **T0:** if Run=1, IRin=1 and go to T1. If Run=0, stay in T0; IR, registers and outputs hold.
- **mv / mvi / mvnz:** complete in T1.
  - mv: bus=Ry, Rin=Rx.
  - mvi: bus=DIN, Rin=Rx.
  - mvnz: bus=Ry; Rin=Rx only when Z=0.
  - Done=1 in T1 in all three cases.
- **add / sub / and:**
  - T1: bus=Rx, Ain.
  - T2: bus=Ry, Gin, Zin.
  - T3: bus=G, Rin=Rx, Done.
- **ld:**
  - T1: bus=Ry, ADDRin.
  - T2: wait for the 1-cycle RAM read.
  - T3: bus=DIN, Rin=Rx, Done.
- **st:**
  - T1: bus=Ry, ADDRin.
  - T2: bus=Rx, DOUTin, W_next=1, Done.
- **W strobe:** W is high for exactly the one cycle after st-T2. ADDR and DOUT stay stable through that cycle.
- **Arithmetic:** modulo 2^`DATA_W`; sub is two's complement; carry and borrow are discarded.
- **Z flag:** Z = (ALU result == 0), loaded only at the T2 edge of add/sub/and. Z is unaffected by all other instructions.
- **Bus mux:** one-hot select over DIN, G, R0-R7. When no source is selected (T0, ld T2), bus = DIN.
- **Rx = Ry:** legal for every opcode. The source is read before the write edge.

## Timing
- **Reset values:** R0-R7, A, G, IR, Z, ADDR, DOUT and W all = 0; Tstep = T0.
  - Done = 0 while Reset=1.
  - BusWires = DIN after reset, since nothing is selected in T0.
- **Reset during an instruction:** at the edge with Reset=1, the pending Rx, G and memory writes are not committed, and W is forced to 0 that same edge.
- **Latency, counting the T0 fetch cycle:**
  - mv, mvi, mvnz: 2 cycles.
  - st: 3 cycles.
  - add, sub, and, ld: 4 cycles.
- **Back-to-back issue:** Run held high issues the next fetch in the cycle after Done, with no bubble.
- **mvi immediate:** sampled on the T1 edge; the source must present the immediate in that cycle.
- **ld return data:** `DIN` must carry the RAM output during T3. The RAM registers ADDR at the T2 edge.
- **Done:** purely combinational from Tstep and IR; never registered.

## Test plan
- **Reset:** hold Reset=1 for 2 cycles with Run=1 and DIN toggling → Done=0, W=0, ADDR=0, DOUT=0, all registers 0; Tstep stays T0 while Reset=1.
- **Add/sub and Z:** mvi R0,5; mvi R1,3; add R0,R1 → R0=8, Done only in T3, Z=0. Then sub R1,R1 → R1=0, Z=1.
- **Wrap-around and mvnz** (DATA_W=16):
  - R2=0xFFFF, R3=1; add R2,R3 → R2=0x0000, Z=1.
  - mvnz R4,R3 → R4 stays 0.
  - and R3,R3 → Z=0; then mvnz R4,R3 → R4=1.
- **Store/load:** R5=0x0010, R6=0xABCD.
  - st R6,[R5] → ADDR=0x0010, DOUT=0xABCD, W=1 for exactly one cycle.
  - ld R7,[R5] with a RAM model → R7=0xABCD after 4 cycles.
- **Run and mid-op reset:**
  - Run=0 for 5 cycles → IR unchanged, no Done.
  - Reset asserted in T2 of an add → Rx unchanged (0), Tstep=T0, Done=0 next cycle.
- **DATA_W=12 instance:** mvi R0,0xFFF; add R0,R0 → R0=0xFFE, Z=0; the upper 9 DIN bits decode correctly.

Source files
------------

// File: rtl/param_proc_if.sv
// param_proc_if
//   Bus bundle between param_proc and its surroundings: the instruction/data
//   source driving DIN and the external synchronous RAM.
//   Ports (signals):
//     Run      - instruction fetch qualifier, looked at only in step T0
//     DIN      - instruction word, mvi immediate, or RAM read data
//     Done     - combinational, high in the last step of each instruction
//     BusWires - the processor's internal bus, exposed for observation
//     ADDR     - registered memory address
//     DOUT     - registered memory write data
//     W        - registered memory write strobe
//   Modports:
//     master - the processor side (drives Done/BusWires/ADDR/DOUT/W)
//     slave  - the environment side (drives Run/DIN)
interface param_proc_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = DATA_W
);
  logic              Run;
  logic [DATA_W-1:0] DIN;
  logic              Done;
  logic [DATA_W-1:0] BusWires;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] DOUT;
  logic              W;

  modport master (
    input  Run, DIN,
    output Done, BusWires, ADDR, DOUT, W
  );

  modport slave (
    output Run, DIN,
    input  Done, BusWires, ADDR, DOUT, W
  );
endinterface

// File: rtl/param_proc.sv
// param_proc
//   Multicycle bus-based processor with DATA_W-bit registers R0-R7, an
//   accumulator input A, ALU result G and a zero flag Z. Instructions are the
//   top 9 bits of a DIN word (III XXX YYY): mv, mvi, add, sub, and, mvnz,
//   ld and st. A 2-bit step counter sequences T0-T3; T0 fetches when Run=1.
//   Ports:
//     Clock - rising-edge clock for all state
//     Reset - synchronous, active-high; clears every register
//     bus   - param_proc_if master modport (Run, DIN in; Done, BusWires,
//             ADDR, DOUT, W out)
//   ADDR_W must not exceed DATA_W; the address is the low ADDR_W bits of Ry.
module param_proc #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = DATA_W
) (
  input  logic         Clock,
  input  logic         Reset,
  param_proc_if.master bus
);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVNZ = 3'b101;
  localparam logic [2:0] OP_LD   = 3'b110;
  localparam logic [2:0] OP_ST   = 3'b111;

  // One-hot bus source positions: 0-7 are R0-R7, then G, then DIN.
  localparam int SEL_G   = 8;
  localparam int SEL_DIN = 9;

  logic [DATA_W-1:0] r_q [8];
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] g_q;
  logic [8:0]        ir_q;
  logic              z_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;
  logic              w_q;
  logic              w_d;
  logic [1:0]        tstep_q;
  logic [1:0]        tstep_d;

  logic [2:0]        opcode;
  logic [2:0]        rx;
  logic [2:0]        ry;

  logic              irIn;
  logic              rIn;
  logic              aIn;
  logic              gIn;
  logic              zIn;
  logic              addrIn;
  logic              doutIn;
  logic              doneC;
  logic [9:0]        busSel;
  logic [DATA_W-1:0] busVal;
  logic [DATA_W-1:0] aluResult;

  assign opcode = ir_q[8:6];
  assign rx     = ir_q[5:3];
  assign ry     = ir_q[2:0];

  // Control decode: turns the current step and opcode into bus source
  // selects and register load enables. Anything not asserted here holds.
  always_comb begin
    irIn   = 1'b0;
    rIn    = 1'b0;
    aIn    = 1'b0;
    gIn    = 1'b0;
    zIn    = 1'b0;
    addrIn = 1'b0;
    doutIn = 1'b0;
    w_d    = 1'b0;
    doneC  = 1'b0;
    busSel = '0;
    case (tstep_q)
      T0: begin
        irIn = bus.Run;
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            busSel[ry] = 1'b1;
            rIn        = 1'b1;
            doneC      = 1'b1;
          end
          OP_MVI: begin
            busSel[SEL_DIN] = 1'b1;
            rIn             = 1'b1;
            doneC           = 1'b1;
          end
          OP_MVNZ: begin
            // Completes either way; only the register write depends on Z.
            busSel[ry] = 1'b1;
            rIn        = ~z_q;
            doneC      = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            busSel[rx] = 1'b1;
            aIn        = 1'b1;
          end
          default: begin
            // ld and st both start by latching the address from Ry.
            busSel[ry] = 1'b1;
            addrIn     = 1'b1;
          end
        endcase
      end
      T2: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND: begin
            busSel[ry] = 1'b1;
            gIn        = 1'b1;
            zIn        = 1'b1;
          end
          OP_ST: begin
            busSel[rx] = 1'b1;
            doutIn     = 1'b1;
            w_d        = 1'b1;
            doneC      = 1'b1;
          end
          default: begin
            // ld spends this step waiting on the RAM's registered read.
          end
        endcase
      end
      default: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND: begin
            busSel[SEL_G] = 1'b1;
            rIn           = 1'b1;
            doneC         = 1'b1;
          end
          OP_LD: begin
            busSel[SEL_DIN] = 1'b1;
            rIn             = 1'b1;
            doneC           = 1'b1;
          end
          default: begin
          end
        endcase
      end
    endcase
  end

  // Bus multiplexer: AND-OR over the one-hot select. With no source
  // selected the bus falls back to DIN so fetches see the instruction.
  always_comb begin
    busVal = '0;
    for (int i = 0; i < 8; i++) begin
      if (busSel[i]) begin
        busVal = busVal | r_q[i];
      end
    end
    if (busSel[SEL_G]) begin
      busVal = busVal | g_q;
    end
    if (busSel[SEL_DIN] || (busSel == '0)) begin
      busVal = busVal | bus.DIN;
    end
  end

  // ALU: A combined with the bus. Results wrap modulo 2^DATA_W.
  always_comb begin
    case (opcode)
      OP_SUB:  aluResult = a_q - busVal;
      OP_AND:  aluResult = a_q & busVal;
      default: aluResult = a_q + busVal;
    endcase
  end

  // Step counter: back to T0 after any Done step, parked in T0 while Run
  // is low, otherwise advancing one step per cycle.
  always_comb begin
    tstep_d = tstep_q;
    if (doneC) begin
      tstep_d = T0;
    end else if ((tstep_q != T0) || bus.Run) begin
      tstep_d = tstep_q + 2'd1;
    end
  end

  // State update. Reset wins over every pending load, so a write that
  // would have landed on the reset edge (Rx, G, Z, memory) is dropped.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < 8; i++) begin
        r_q[i] <= '0;
      end
      a_q     <= '0;
      g_q     <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      w_q     <= 1'b0;
      tstep_q <= T0;
    end else begin
      tstep_q <= tstep_d;
      w_q     <= w_d;
      if (irIn) begin
        ir_q <= bus.DIN[DATA_W-1 -: 9];
      end
      if (rIn) begin
        r_q[rx] <= busVal;
      end
      if (aIn) begin
        a_q <= busVal;
      end
      if (gIn) begin
        g_q <= aluResult;
      end
      if (zIn) begin
        z_q <= (aluResult == '0);
      end
      if (addrIn) begin
        addr_q <= busVal[ADDR_W-1:0];
      end
      if (doutIn) begin
        dout_q <= busVal;
      end
    end
  end

  // Done is masked by Reset so nothing completes while reset is held.
  assign bus.Done     = doneC & ~Reset;
  assign bus.BusWires = busVal;
  assign bus.ADDR     = addr_q;
  assign bus.DOUT     = dout_q;
  assign bus.W        = w_q;

endmodule
